reorder_buffer: RTL and testbench



---
 rtl/reorder_buffer_pkg.sv | 23 ++
 rtl/reorder_buffer_ptr_ctr.sv | 29 ++
 rtl/reorder_buffer.sv | 158 +++++++++++++++
 tb/tb_reorder_buffer.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared types and defaults for the reorder buffer.
//   ROB_Entry       - per-instruction payload carried from Dispatch to commit
//   rob_state_e     - RUN / FLUSH control state
//   ROB_DEPTH_DEFAULT, ROB_IDX_W - default depth and its index width
package reorder_buffer_pkg;

  localparam int ROB_DEPTH_DEFAULT = 16;
  localparam int ROB_IDX_W         = $clog2(ROB_DEPTH_DEFAULT);
  localparam int PC_W              = 32;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [4:0]      rd;
    logic            rd_wen;
    logic            is_branch;
  } ROB_Entry;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } rob_state_e;

endpackage

// File: rtl/reorder_buffer_ptr_ctr.sv
// rob_ptr_ctr: wrapping pointer used for the ROB head and tail.
// Ports:
//   clk, rst_n - clock, synchronous active-low reset
//   i_inc      - advance pointer by one (wraps naturally, depth is 2^W)
//   i_clr      - return pointer to 0; has priority over i_inc
//   o_ptr      - current pointer value
module rob_ptr_ctr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_ptr
);

  logic [W-1:0] r_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n || i_clr) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= r_ptr + W'(1);
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer: circular ROB. Allocates one entry per cycle from Dispatch,
// records out-of-order writeback completions and retires in program order.
// Optional build macro: ROB_EXCEPTION_EN - store per-entry exceptions, expose
// them on commit_exception and flush the ROB after an excepting commit.
// Ports:
//   clk, rst_n                      - clock, synchronous active-low reset
//   new_entry, entry_valid          - allocation request from Dispatch
//   rob_index, rob_full             - tail index / allocation refused (registered)
//   rob_empty                       - no valid entries
//   wb_valid, wb_index, wb_result,
//   wb_exception                    - completion from execute/writeback
//   commit_valid, commit_ready      - in-order retire handshake
//   commit_entry, commit_result,
//   commit_index, commit_exception  - head slot contents
//   flush                           - squash everything
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_DEPTH = ROB_DEPTH_DEFAULT,
  parameter int XLEN      = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  ROB_Entry                     new_entry,
  input  logic                         entry_valid,
  output logic [$clog2(ROB_DEPTH)-1:0] rob_index,
  output logic                         rob_full,
  output logic                         rob_empty,
  input  logic                         wb_valid,
  input  logic [$clog2(ROB_DEPTH)-1:0] wb_index,
  input  logic [XLEN-1:0]              wb_result,
  input  logic                         wb_exception,
  output logic                         commit_valid,
  input  logic                         commit_ready,
  output ROB_Entry                     commit_entry,
  output logic [XLEN-1:0]              commit_result,
  output logic [$clog2(ROB_DEPTH)-1:0] commit_index,
  output logic                         commit_exception,
  input  logic                         flush
);

  localparam int IDX_W = $clog2(ROB_DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(ROB_DEPTH);

  rob_state_e           r_state;
  logic [CNT_W-1:0]     r_count;
  logic [ROB_DEPTH-1:0] r_valid;
  logic [ROB_DEPTH-1:0] r_done;
  logic [ROB_DEPTH-1:0] r_exc;
  ROB_Entry             r_entry  [ROB_DEPTH];
  logic [XLEN-1:0]      r_result [ROB_DEPTH];

  logic [IDX_W-1:0] w_head;
  logic [IDX_W-1:0] w_tail;
  logic             w_full;
  logic             w_commit_valid;
  logic             w_alloc;
  logic             w_wb;
  logic             w_commit;
  logic             w_wb_exc;
  logic             w_head_exc;
  logic             w_exc_flush;
  logic             w_go_flush;

  // Full depends only on registered count/state, never on entry_valid.
  assign w_full         = (r_count == FULL_CNT) || (r_state == FLUSH);
  assign w_commit_valid = r_valid[w_head] && r_done[w_head] && (r_state == RUN);
  assign w_head_exc     = r_exc[w_head];

  // External flush dominates every other same-cycle action.
  assign w_alloc  = entry_valid && !w_full && !flush;
  assign w_wb     = wb_valid && r_valid[wb_index] && !flush;
  assign w_commit = w_commit_valid && commit_ready && !flush;

`ifdef ROB_EXCEPTION_EN
  assign w_wb_exc         = wb_exception;
  assign w_exc_flush      = w_commit && w_head_exc;
  assign commit_exception = w_head_exc;
`else
  logic [1:0] w_unused_exc;
  assign w_unused_exc     = {wb_exception, w_head_exc};
  assign w_wb_exc         = 1'b0;
  assign w_exc_flush      = 1'b0;
  assign commit_exception = 1'b0;
`endif

  assign w_go_flush = flush || w_exc_flush;

  rob_ptr_ctr #(.W(IDX_W)) u_head (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_commit),
    .i_clr (w_go_flush),
    .o_ptr (w_head)
  );

  rob_ptr_ctr #(.W(IDX_W)) u_tail (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_alloc),
    .i_clr (w_go_flush),
    .o_ptr (w_tail)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_count <= '0;
      r_valid <= '0;
      r_done  <= '0;
      r_exc   <= '0;
      for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
        r_entry[i]  <= '0;
        r_result[i] <= '0;
      end
    end else if (w_go_flush) begin
      // An excepting commit squashes any same-cycle allocation as well.
      r_state <= FLUSH;
      r_count <= '0;
      r_valid <= '0;
      r_done  <= '0;
      r_exc   <= '0;
    end else begin
      r_state <= RUN;
      if (w_alloc) begin
        r_valid[w_tail] <= 1'b1;
        r_done[w_tail]  <= 1'b0;
        r_exc[w_tail]   <= 1'b0;
        r_entry[w_tail] <= new_entry;
      end
      if (w_wb) begin
        r_done[wb_index]   <= 1'b1;
        r_exc[wb_index]    <= w_wb_exc;
        r_result[wb_index] <= wb_result;
      end
      if (w_commit) begin
        r_valid[w_head] <= 1'b0;
        r_done[w_head]  <= 1'b0;
        r_exc[w_head]   <= 1'b0;
      end
      unique case ({w_alloc, w_commit})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign rob_index     = w_tail;
  assign rob_full      = w_full;
  assign rob_empty     = (r_count == '0);
  assign commit_valid  = w_commit_valid;
  assign commit_entry  = r_entry[w_head];
  assign commit_result = r_result[w_head];
  assign commit_index  = w_head;

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus randomized
// traffic, all compared against a queue-based model of the ROB.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  localparam int DEPTH = 16;
`ifdef ROB_EXCEPTION_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  ROB_Entry    new_entry = '0;
  logic        entry_valid = 1'b0;
  logic [3:0]  rob_index;
  logic        rob_full;
  logic        rob_empty;
  logic        wb_valid = 1'b0;
  logic [3:0]  wb_index = '0;
  logic [31:0] wb_result = '0;
  logic        wb_exception = 1'b0;
  logic        commit_valid;
  logic        commit_ready = 1'b0;
  ROB_Entry    commit_entry;
  logic [31:0] commit_result;
  logic [3:0]  commit_index;
  logic        commit_exception;
  logic        flush = 1'b0;

  always #5 clk = ~clk;

  reorder_buffer #(.ROB_DEPTH(DEPTH), .XLEN(32)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .new_entry        (new_entry),
    .entry_valid      (entry_valid),
    .rob_index        (rob_index),
    .rob_full         (rob_full),
    .rob_empty        (rob_empty),
    .wb_valid         (wb_valid),
    .wb_index         (wb_index),
    .wb_result        (wb_result),
    .wb_exception     (wb_exception),
    .commit_valid     (commit_valid),
    .commit_ready     (commit_ready),
    .commit_entry     (commit_entry),
    .commit_result    (commit_result),
    .commit_index     (commit_index),
    .commit_exception (commit_exception),
    .flush            (flush)
  );

  // Reference model: a program-ordered queue of in-flight instructions.
  typedef struct {
    logic [3:0]  idx;
    ROB_Entry    e;
    bit          done;
    bit          exc;
    logic [31:0] res;
  } mslot_t;

  mslot_t mq[$];
  int     m_tail;
  bit     m_flushing;
  int     n_pass;
  int     n_total;

  logic [7:0]  dut_status;
  logic [74:0] dut_payload;
  assign dut_status  = {rob_full, rob_empty, commit_valid, commit_exception, rob_index};
  assign dut_payload = {commit_index, commit_entry, commit_result};

  function automatic bit m_full();
    return (mq.size() == DEPTH) || m_flushing;
  endfunction

  function automatic bit m_cv();
    return !m_flushing && (mq.size() > 0) && mq[0].done;
  endfunction

  function automatic logic [7:0] m_status();
    bit cexc;
    cexc = (mq.size() > 0) && mq[0].exc;
    return {m_full(), mq.size() == 0, m_cv(), cexc, 4'(m_tail)};
  endfunction

  function automatic logic [74:0] m_payload();
    return {mq[0].idx, mq[0].e, mq[0].res};
  endfunction

  function automatic ROB_Entry rand_entry();
    ROB_Entry e;
    e.pc        = $urandom;
    e.rd        = 5'($urandom);
    e.rd_wen    = 1'($urandom);
    e.is_branch = 1'($urandom);
    return e;
  endfunction

  // Applies one clock edge of the specified behaviour to the model.
  task automatic m_edge();
    bit     alloc, commit, xflush;
    mslot_t s;
    alloc  = entry_valid && !m_full() && !flush;
    commit = m_cv() && commit_ready && !flush;
    xflush = EXC_EN && commit && mq[0].exc;
    if (flush || xflush) begin
      mq.delete();
      m_tail     = 0;
      m_flushing = 1'b1;
    end else begin
      m_flushing = 1'b0;
      if (wb_valid) begin
        foreach (mq[k]) begin
          if (mq[k].idx == wb_index) begin
            mq[k].done = 1'b1;
            mq[k].res  = wb_result;
            mq[k].exc  = EXC_EN && wb_exception;
          end
        end
      end
      if (commit) void'(mq.pop_front());
      if (alloc) begin
        s.idx  = 4'(m_tail);
        s.e    = new_entry;
        s.done = 1'b0;
        s.exc  = 1'b0;
        s.res  = '0;
        mq.push_back(s);
        m_tail = (m_tail + 1) % DEPTH;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_edge();
    #1;
  endtask

  task automatic idle();
    entry_valid  = 1'b0;
    wb_valid     = 1'b0;
    wb_index     = '0;
    wb_result    = '0;
    wb_exception = 1'b0;
    commit_ready = 1'b0;
    flush        = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    mq.delete();
    m_tail     = 0;
    m_flushing = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  task automatic alloc_n(input int n);
    for (int i = 0; i < n; i++) begin
      entry_valid = 1'b1;
      new_entry   = rand_entry();
      tick();
    end
    entry_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++;
    if (dut_status !== 8'b0100_0000) $display("FAIL reset_status: got %b expected %b", dut_status, 8'b0100_0000);
    else n_pass++;
    n_total++;
    if (dut_payload !== '0) $display("FAIL reset_payload: got %h expected 0", dut_payload);
    else n_pass++;
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      n_total++;
      if (rob_index !== 4'(i) || rob_full !== 1'b0)
        $display("FAIL fill_index[%0d]: got idx %0d full %b expected idx %0d full 0", i, rob_index, rob_full, i);
      else n_pass++;
      entry_valid = 1'b1;
      new_entry   = rand_entry();
      tick();
    end
    n_total++;
    if (rob_full !== 1'b1 || dut_status !== m_status())
      $display("FAIL fill_full: got %b expected %b", dut_status, m_status());
    else n_pass++;
    new_entry = rand_entry();
    tick();
    entry_valid = 1'b0;
    n_total++;
    if (rob_index !== 4'd0 || dut_status !== m_status())
      $display("FAIL fill_refused: got %b expected %b", dut_status, m_status());
    else n_pass++;
  endtask

  task automatic test_ooo_wb();
    do_reset();
    alloc_n(3);
    wb_valid = 1'b1; wb_index = 4'd2; wb_result = $urandom;
    tick();
    n_total++;
    if (commit_valid !== 1'b0) $display("FAIL ooo_wb2_cv: got %b expected 0", commit_valid);
    else n_pass++;
    wb_index = 4'd0; wb_result = $urandom;
    #1;
    n_total++;
    if (commit_valid !== 1'b0) $display("FAIL ooo_no_bypass: got %b expected 0", commit_valid);
    else n_pass++;
    tick();
    wb_valid = 1'b0;
    n_total++;
    if (commit_valid !== 1'b1 || commit_index !== 4'd0 || dut_payload !== m_payload())
      $display("FAIL ooo_commit0: got cv %b %h expected cv 1 %h", commit_valid, dut_payload, m_payload());
    else n_pass++;
    commit_ready = 1'b1;
    tick();
    commit_ready = 1'b0;
    n_total++;
    if (commit_valid !== 1'b0 || commit_index !== 4'd1)
      $display("FAIL ooo_head1_wait: got cv %b idx %0d expected cv 0 idx 1", commit_valid, commit_index);
    else n_pass++;
    wb_valid = 1'b1; wb_index = 4'd1; wb_result = $urandom;
    tick();
    wb_valid = 1'b0;
    n_total++;
    if (commit_valid !== 1'b1 || commit_index !== 4'd1 || dut_payload !== m_payload())
      $display("FAIL ooo_commit1: got cv %b %h expected cv 1 %h", commit_valid, dut_payload, m_payload());
    else n_pass++;
    commit_ready = 1'b1;
    tick();
    n_total++;
    if (commit_valid !== 1'b1 || commit_index !== 4'd2 || dut_payload !== m_payload())
      $display("FAIL ooo_commit2: got cv %b %h expected cv 1 %h", commit_valid, dut_payload, m_payload());
    else n_pass++;
    tick();
    commit_ready = 1'b0;
    n_total++;
    if (rob_empty !== 1'b1 || dut_status !== m_status())
      $display("FAIL ooo_drained: got %b expected %b", dut_status, m_status());
    else n_pass++;
  endtask

  task automatic test_full_commit();
    do_reset();
    alloc_n(DEPTH);
    wb_valid = 1'b1; wb_index = 4'd0; wb_result = $urandom;
    tick();
    wb_valid = 1'b0;
    n_total++;
    if (commit_valid !== 1'b1 || rob_full !== 1'b1)
      $display("FAIL fullc_ready: got cv %b full %b expected 1 1", commit_valid, rob_full);
    else n_pass++;
    entry_valid = 1'b1; new_entry = rand_entry(); commit_ready = 1'b1;
    tick();
    commit_ready = 1'b0;
    n_total++;
    if (rob_index !== 4'd0 || rob_full !== 1'b0 || commit_index !== 4'd1 || dut_status !== m_status())
      $display("FAIL fullc_refused: got %b head %0d expected %b head 1", dut_status, commit_index, m_status());
    else n_pass++;
    new_entry = rand_entry();
    tick();
    entry_valid = 1'b0;
    n_total++;
    if (rob_index !== 4'd1 || rob_full !== 1'b1 || dut_status !== m_status())
      $display("FAIL fullc_accept: got %b expected %b", dut_status, m_status());
    else n_pass++;
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      alloc_n(1);
      n_total++;
      if (rob_empty !== 1'b0 || dut_status !== m_status())
        $display("FAIL wrap_alloc[%0d]: got %b expected %b", i, dut_status, m_status());
      else n_pass++;
      wb_valid = 1'b1; wb_index = 4'(i % DEPTH); wb_result = $urandom;
      tick();
      wb_valid = 1'b0;
      n_total++;
      if (commit_valid !== 1'b1 || commit_index !== 4'(i % DEPTH) || dut_payload !== m_payload())
        $display("FAIL wrap_head[%0d]: got cv %b %h expected cv 1 %h", i, commit_valid, dut_payload, m_payload());
      else n_pass++;
      commit_ready = 1'b1;
      tick();
      commit_ready = 1'b0;
      n_total++;
      if (rob_index !== 4'((i + 1) % DEPTH) || rob_empty !== 1'b1)
        $display("FAIL wrap_index[%0d]: got idx %0d empty %b expected idx %0d empty 1", i, rob_index, rob_empty, (i + 1) % DEPTH);
      else n_pass++;
    end
  endtask

  task automatic test_flush();
    do_reset();
    alloc_n(5);
    entry_valid = 1'b1; new_entry = rand_entry(); flush = 1'b1;
    tick();
    flush = 1'b0;
    n_total++;
    if (rob_empty !== 1'b1 || rob_full !== 1'b1 || dut_status !== m_status())
      $display("FAIL flush_n1: got %b expected %b", dut_status, m_status());
    else n_pass++;
    new_entry = rand_entry();
    tick();
    n_total++;
    if (rob_index !== 4'd0 || rob_full !== 1'b0 || dut_status !== m_status())
      $display("FAIL flush_n2: got %b expected %b", dut_status, m_status());
    else n_pass++;
    new_entry = rand_entry();
    tick();
    entry_valid = 1'b0;
    n_total++;
    if (rob_index !== 4'd1 || rob_empty !== 1'b0 || dut_status !== m_status())
      $display("FAIL flush_realloc: got %b expected %b", dut_status, m_status());
    else n_pass++;
  endtask

  task automatic test_exception();
    bit exp_flushed;
    exp_flushed = EXC_EN;
    do_reset();
    alloc_n(2);
    wb_valid = 1'b1; wb_index = 4'd0; wb_result = $urandom; wb_exception = 1'b1;
    tick();
    wb_valid = 1'b0; wb_exception = 1'b0;
    n_total++;
    if (commit_valid !== 1'b1 || commit_exception !== exp_flushed || dut_payload !== m_payload())
      $display("FAIL exc_head: got cv %b exc %b expected cv 1 exc %b", commit_valid, commit_exception, exp_flushed);
    else n_pass++;
    commit_ready = 1'b1;
    tick();
    commit_ready = 1'b0;
    n_total++;
    if (rob_empty !== exp_flushed || rob_full !== exp_flushed || dut_status !== m_status())
      $display("FAIL exc_after: got %b expected %b", dut_status, m_status());
    else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 500; c++) begin
      entry_valid  = ($urandom_range(0, 9) < 6);
      new_entry    = rand_entry();
      wb_valid     = ($urandom_range(0, 1) == 1);
      if (mq.size() > 0 && $urandom_range(0, 3) != 0)
        wb_index = mq[$urandom_range(0, mq.size() - 1)].idx;
      else
        wb_index = 4'($urandom);
      wb_result    = $urandom;
      wb_exception = ($urandom_range(0, 7) == 0);
      commit_ready = ($urandom_range(0, 9) < 7);
      flush        = ($urandom_range(0, 49) == 0);
      tick();
      n_total++;
      if (dut_status !== m_status())
        $display("FAIL rand_status[%0d]: got %b expected %b", c, dut_status, m_status());
      else n_pass++;
      if (m_cv()) begin
        n_total++;
        if (dut_payload !== m_payload())
          $display("FAIL rand_payload[%0d]: got %h expected %h", c, dut_payload, m_payload());
        else n_pass++;
      end
    end
    idle();
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    m_tail  = 0;
    m_flushing = 1'b0;
    test_reset();
    test_fill();
    test_ooo_wb();
    test_full_commit();
    test_wrap();
    test_flush();
    test_exception();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
